// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Shared types and timing helpers for the WS2812B strip driver.
//   state_t               : driver FSM states
//   WS2812_BITS_PER_PIXEL : colour bits sent per pixel (wire order G,R,B)
//   bit_cyc/t0h_cyc/t1h_cyc/reset_cyc : clock-cycle counts from clock frequency
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_GAP
  } state_t;

  localparam int WS2812_BITS_PER_PIXEL = 24;

  // 1.25 us bit period
  function automatic int bit_cyc(input int f);
    return f / 800_000;
  endfunction

  // 0.4 us high time for a 0 bit
  function automatic int t0h_cyc(input int f);
    return f / 2_500_000;
  endfunction

  // 0.8 us high time for a 1 bit
  function automatic int t1h_cyc(input int f);
    return f / 1_250_000;
  endfunction

  // latch gap; whole cycles per microsecond times the gap length
  function automatic int reset_cyc(input int f, input int us);
    return (f / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx
// Emits one WS2812B bit: led_out high for the bit's high time, then low until
// the full bit period has elapsed.
//   clk, rst : clock, async active-high reset
//   start    : begin a bit on the next cycle (sampled with bit_val)
//   bit_val  : value of the bit to send
//   led_out  : registered serial line
//   done     : high on the last cycle of the bit; a start in that cycle
//              makes the next bit follow with no idle cycle
module ws2812_bit_tx #(
  parameter int BIT_CYC = 33,
  parameter int T0H_CYC = 10,
  parameter int T1H_CYC = 21,
  parameter int CNT_W   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic led_out,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] THR_0   = CNT_W'(BIT_CYC - T0H_CYC);
  localparam logic [CNT_W-1:0] THR_1   = CNT_W'(BIT_CYC - T1H_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             active_q;

  assign cnt_nxt = cnt_q - CNT_W'(1);
  assign done    = active_q && (cnt_q == '0);

  // Remaining-cycles down-counter; the line stays high while the remaining
  // count is at or above BIT_CYC-THx, which gives exactly THx high cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      thr_q    <= '0;
      active_q <= 1'b0;
      led_out  <= 1'b0;
    end else if (start) begin
      cnt_q    <= CNT_TOP;
      thr_q    <= bit_val ? THR_1 : THR_0;
      active_q <= 1'b1;
      led_out  <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
        led_out  <= 1'b0;
      end else begin
        cnt_q   <= cnt_nxt;
        led_out <= (cnt_nxt >= thr_q);
      end
    end
  end

endmodule

// File: rtl/led_strip_driver_onoff.sv
// led_strip_driver_onoff
// Drives a WS2812B chain from an on/off vector: each pixel shows ON_COLOR for
// a 1 bit and OFF_COLOR for a 0 bit. Frames repeat back to back while ready.
//   clk, rst      : clock, async active-high reset
//   ready         : latch and send frames while high
//   data          : per-pixel on/off, data[0] nearest the driver
//   busy          : frame or latch gap in progress
//   frame_latched : one-cycle pulse in the cycle data is snapshotted
//   led_out       : serial line to the strip
//
// state  | meaning
// S_IDLE | line low, waiting for ready
// S_DATA | shifting the snapshotted frame out, pixel 0 first, MSB first
// S_GAP  | line low for the latch gap; also the state after reset
module led_strip_driver_onoff
  import ws2812_pkg::*;
#(
  parameter int          CLK_FREQ  = 27_000_000,
  parameter int          NUM_LEDS  = 8,
  parameter logic [23:0] ON_COLOR  = 24'h000f00,
  parameter logic [23:0] OFF_COLOR = 24'h000000,
  parameter int          RESET_US  = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [NUM_LEDS-1:0] data,
  output logic                busy,
  output logic                frame_latched,
  output logic                led_out
);

  localparam int BIT_CYC   = bit_cyc(CLK_FREQ);
  localparam int T0H_CYC   = t0h_cyc(CLK_FREQ);
  localparam int T1H_CYC   = t1h_cyc(CLK_FREQ);
  localparam int RESET_CYC = reset_cyc(CLK_FREQ, RESET_US);
  localparam int MAX_CYC   = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam int PIX_W     = $clog2(NUM_LEDS) + 1;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_LEDS - 1);
  localparam logic [4:0]       MSB_BIT  = 5'(WS2812_BITS_PER_PIXEL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_PRE  = CNT_W'(RESET_CYC - 2);

  if (T0H_CYC < 1 || T1H_CYC >= BIT_CYC) begin : g_bad_timing
    $error("led_strip_driver_onoff: CLK_FREQ gives unusable bit timing");
  end
  if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_leds
    $error("led_strip_driver_onoff: NUM_LEDS must be 1..256");
  end
  if (RESET_US < 50) begin : g_bad_gap
    $error("led_strip_driver_onoff: RESET_US must be at least 50");
  end

  state_t              state_q;
  logic [NUM_LEDS-1:0] frame_q;
  logic [PIX_W-1:0]    pix_q;
  logic [4:0]          bit_q;
  logic [CNT_W-1:0]    gap_q;
  logic                last_q;

  logic        latch_now;
  logic        pixel_on;
  logic [23:0] pixel_color;
  logic        bit_val;
  logic        tx_start;
  logic        tx_done;

  // The latch is taken one cycle early from the gap so that the registered
  // frame_latched pulse lands on the gap's final cycle.
  assign latch_now = ready && ((state_q == S_IDLE) ||
                               (state_q == S_GAP && gap_q == GAP_PRE));

  // pix_q/bit_q always point at the next bit to hand to the transmitter;
  // the first bit goes out from the latch cycle, the rest on each done.
  assign tx_start = (state_q == S_DATA) && (frame_latched || (tx_done && !last_q));
  assign busy     = !rst && (state_q != S_IDLE);

  always_comb begin
    pixel_on = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (pix_q == PIX_W'(i)) pixel_on = frame_q[i];
    end
    pixel_color = pixel_on ? ON_COLOR : OFF_COLOR;
    bit_val     = pixel_color[bit_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_GAP;
      frame_q       <= '0;
      pix_q         <= '0;
      bit_q         <= '0;
      gap_q         <= '0;
      last_q        <= 1'b0;
      frame_latched <= 1'b0;
    end else begin
      frame_latched <= 1'b0;
      if (latch_now) begin
        frame_q       <= data;
        frame_latched <= 1'b1;
        pix_q         <= '0;
        bit_q         <= MSB_BIT;
        gap_q         <= '0;
        last_q        <= 1'b0;
        state_q       <= S_DATA;
      end else begin
        case (state_q)
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              gap_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (tx_start) begin
              if (pix_q == LAST_PIX && bit_q == '0) begin
                last_q <= 1'b1;
              end else if (bit_q == '0) begin
                bit_q <= MSB_BIT;
                pix_q <= pix_q + PIX_W'(1);
              end else begin
                bit_q <= bit_q - 5'd1;
              end
            end
            if (tx_done && last_q) begin
              last_q  <= 1'b0;
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ws2812_bit_tx #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .CNT_W   (CNT_W)
  ) u_bit_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (tx_start),
    .bit_val (bit_val),
    .led_out (led_out),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_led_strip_driver_onoff.sv
module tb_led_strip_driver_onoff;

  localparam int N       = 3;
  localparam int BIT     = 33;
  localparam int T0H     = 10;
  localparam int T1H     = 21;
  localparam int GAP     = 2160;
  localparam int FRAME   = N * 24 * BIT;
  localparam int SPACING = FRAME + GAP;
  localparam logic [23:0] ON_C  = 24'h000f00;
  localparam logic [23:0] OFF_C = 24'h000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ready = 1'b0;
  logic [N-1:0] data = '0;
  logic         busy, frame_latched, led_out;

  always #5 clk = ~clk;

  led_strip_driver_onoff #(.NUM_LEDS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .data          (data),
    .busy          (busy),
    .frame_latched (frame_latched),
    .led_out       (led_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: what each pixel should show for a given on/off snapshot.
  function automatic logic [23:0] model_color(input logic [N-1:0] d, input int i);
    return d[i] ? ON_C : OFF_C;
  endfunction

  // Line monitor, sampled on the falling edge.
  int   cyc = 0;
  logic led_prev = 1'b0;
  int   hi_cnt = 0;
  int   rise_q[$];
  int   width_q[$];
  int   fl_q[$];
  bit   busy_watch = 1'b0;
  int   busy_low = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (led_out && !led_prev) begin
      rise_q.push_back(cyc);
      hi_cnt = 1;
    end else if (led_out) begin
      hi_cnt = hi_cnt + 1;
    end
    if (!led_out && led_prev) width_q.push_back(hi_cnt);
    led_prev = led_out;
    if (frame_latched) fl_q.push_back(cyc);
    if (busy_watch && !busy) busy_low = busy_low + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic wait_latch(output int l, input int budget);
    int n;
    n = 0;
    while (fl_q.size() == 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (fl_q.size() == 0) begin
      check("latch_timeout", 0, 1);
      l = cyc;
    end else begin
      l = fl_q.pop_front();
    end
    rise_q.delete();
    width_q.delete();
  endtask

  // Decode the frame that was latched at sample l and compare it with the
  // expected pixel colours.
  task automatic check_frame(input int l, input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] e2, input string tag);
    int bad_per, bad_w, w, nr;
    logic [23:0] got [N];
    wait_until(l + FRAME + 2);
    nr = rise_q.size();
    check({tag, "_nbits"}, nr, N * 24);
    if (nr < N * 24 || width_q.size() < N * 24) return;
    check({tag, "_first_rise"}, rise_q[0] - l, 1);
    bad_per = 0;
    bad_w = 0;
    for (int i = 0; i < N; i++) got[i] = '0;
    for (int i = 0; i < N * 24; i++) begin
      if (rise_q[i] - rise_q[0] != i * BIT) bad_per++;
      w = width_q[i];
      if (w != T0H && w != T1H) bad_w++;
      got[i / 24] = {got[i / 24][22:0], (w == T1H)};
    end
    check({tag, "_bit_period"}, bad_per, 0);
    check({tag, "_high_width"}, bad_w, 0);
    check({tag, "_frame_len"}, rise_q[N * 24 - 1] + BIT - rise_q[0], FRAME);
    check({tag, "_pix0"}, int'(got[0]), int'(e0));
    check({tag, "_pix1"}, int'(got[1]), int'(e1));
    check({tag, "_pix2"}, int'(got[2]), int'(e2));
    check({tag, "_single_pulse"}, fl_q.size(), 0);
  endtask

  typedef struct {
    logic [N-1:0] d_latch;
    logic [N-1:0] d_mid;
    logic [23:0]  e0, e1, e2;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cnt, l, prev_l;
    logic [N-1:0] d;

    vecs[0] = '{3'b101, 3'b010, ON_C,  OFF_C, ON_C};
    vecs[1] = '{3'b010, 3'b111, OFF_C, ON_C,  OFF_C};
    vecs[2] = '{3'b110, 3'b001, OFF_C, ON_C,  ON_C};
    for (int i = 3; i < 6; i++) begin
      vecs[i].d_latch = N'($urandom);
      vecs[i].d_mid   = N'($urandom);
      vecs[i].e0 = model_color(vecs[i].d_latch, 0);
      vecs[i].e1 = model_color(vecs[i].d_latch, 1);
      vecs[i].e2 = model_color(vecs[i].d_latch, 2);
    end

    // Reset state
    tick(3);
    check("rst_led", int'(led_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_latched", int'(frame_latched), 0);

    // Gap after reset with ready low, then idle
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    tick(1);
    while (busy === 1'b1 && cnt < 5000) begin
      cnt++;
      tick(1);
    end
    check("init_gap_busy_len", cnt, GAP);
    tick(10);
    check("idle_busy", int'(busy), 0);
    check("idle_led", int'(led_out), 0);
    check("idle_no_latch", fl_q.size(), 0);
    check("idle_no_rise", rise_q.size(), 0);

    // Back-to-back frames, data changed mid-frame
    ready = 1'b1;
    prev_l = 0;
    for (int i = 0; i < 6; i++) begin
      data = vecs[i].d_latch;
      wait_latch(l, SPACING + 100);
      if (i == 0) busy_watch = 1'b1;
      else check($sformatf("v%0d_latch_spacing", i), l - prev_l, SPACING);
      wait_until(l + 100);
      data = vecs[i].d_mid;
      check_frame(l, vecs[i].e0, vecs[i].e1, vecs[i].e2, $sformatf("v%0d", i));
      prev_l = l;
    end

    // ready dropped mid-frame: frame and gap finish, then idle
    d = 3'b011;
    data = d;
    wait_latch(l, SPACING + 100);
    check("b2b_latch_spacing", l - prev_l, SPACING);
    busy_watch = 1'b0;
    check("b2b_busy_never_low", busy_low, 0);
    wait_until(l + 200);
    ready = 1'b0;
    data = 3'b100;
    check_frame(l, model_color(d, 0), model_color(d, 1), model_color(d, 2), "drop");
    cnt = 0;
    while (busy === 1'b1 && cnt < SPACING) begin
      cnt++;
      tick(1);
    end
    check("drop_busy_fall", cyc - l, SPACING + 1);
    check("drop_gap_no_rise", rise_q.size(), N * 24);
    tick(5000);
    check("drop_no_more_latch", fl_q.size(), 0);

    // rst mid-frame
    ready = 1'b1;
    data = 3'b111;
    wait_latch(l, 100);
    wait_until(l + 5);
    check("pre_rst_led_high", int'(led_out), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_led", int'(led_out), 0);
    check("rst_mid_busy", int'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    fl_q.delete();
    rise_q.delete();
    width_q.delete();
    cnt = 0;
    tick(1);
    while (frame_latched !== 1'b1 && cnt < 5000) begin
      cnt++;
      tick(1);
    end
    check("rst_gap_len", cnt + 1, GAP);
    check("rst_gap_no_rise", rise_q.size(), 0);
    l = cyc;
    fl_q.delete();
    check_frame(l, ON_C, ON_C, ON_C, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
